multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and gates the combinational decoder's RegWEn/MemWEn/PCSel so architectural state changes only in the correct phase. It also shares the single memory port between instruction fetch and data access. It sits between `control_unit`, the PC/IR/register-file write enables and the unified memory.

## Interface
- `WAIT_MAX`, 15: maximum consecutive wait cycles on the memory port before a timeout trap; used only when `MCSEQ_TRAP_EN` is defined.
- `clk` in 1: core clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears state immediately.
- `opcode` in 7: `IR[6:0]`; valid from DECODE onward.
- `mem_we_dec` in 2: decoder MemWEn (00 none, 01 SB, 10 SH, 11 SW).
- `reg_wen_dec` in 1: decoder RegWEn.
- `pcsel_dec` in 1: decoder PCSel (branch outcome already resolved).
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_addr_sel` out 1: 0 = PC (fetch), 1 = ALU result (data).
- `mem_wen` out 2: gated store-size strobe.
- `ir_we` out 1: load IR.
- `mdr_we` out 1: latch load data.
- `rf_we` out 1: gated register-file write.
- `pc_we` out 1: PC update.
- `pc_sel` out 1: 0 = PC+4, 1 = ALU target; meaningful only with `pc_we`.
- `instret` out 1: one-cycle pulse per retired instruction.
- `trap` out 1: sticky halt indication; tied 0 without the macro.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **IDLE**: entered on reset; all outputs 0; moves to FETCH on the next edge.
- **FETCH**: `mem_req=1`, `mem_addr_sel=0`, `mem_wen=0`. Stays while `!mem_ready`. On `mem_ready`: `ir_we=1` that cycle, then go to DECODE.
- **DECODE**: one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> go to EXEC.
  - Illegal opcode: see Configuration.
- **EXEC**: one cycle. Opcode 0000011 or 0100011 -> MEM; otherwise -> WB.
- **MEM**: `mem_req=1`, `mem_addr_sel=1`, `mem_wen` = `mem_we_dec` for stores, 0 for loads. Hold all of these stable until `mem_ready`. On `mem_ready`: `mdr_we=1` for loads only, then go to WB.
- **WB**: one cycle.
  - `rf_we=reg_wen_dec`, `pc_we=1`, `pc_sel=pcsel_dec`, `instret=1`.
  - Then go to FETCH.
- **Gating**: `rf_we`, `pc_we` and `instret` are asserted only in WB. `mem_wen` is nonzero only in MEM.
- **`mem_ready` handling**: ignored outside FETCH/MEM. A `mem_ready` that is already high on entry completes the access in its first cycle.

## Timing
- Outputs are Moore on state. Exceptions: `ir_we` and `mdr_we`, which are state AND `mem_ready` (combinational).
- Zero-wait memory: non-memory instruction takes 4 cycles (FETCH, DECODE, EXEC, WB); load/store takes 5.
- Each memory wait cycle adds 1 cycle.
- Reset value of every output is 0.
- Reset asserted mid-FETCH/MEM drops `mem_req` and `mem_wen` asynchronously, in the same cycle. No partial PC/RF update occurs.
- First `mem_req` appears on the 2nd rising edge after `reset` deasserts (IDLE occupies one cycle).

## Configuration
- `MCSEQ_TRAP_EN` defined:
  - Illegal opcode in DECODE -> TRAP.
  - A `mem_req` held for `WAIT_MAX` consecutive cycles without `mem_ready` -> TRAP on the next edge.
  - TRAP: `trap=1`, all other outputs 0. TRAP is left only by `reset`.
- `MCSEQ_TRAP_EN` undefined:
  - Illegal opcode is a NOP: DECODE -> WB with `rf_we=0`, `pc_sel=0`, `pc_we=1`, `instret=1`.
  - Waits are unbounded.
  - `trap` tied 0; no wait counter is instantiated.

## Structure
- `rv32i_pkg` holds: opcode constants (shared with `control_unit`), the state enum, and the MemWEn encoding.
- Sub-module `mem_wait_timer`:
  - Saturating counter of width `$clog2(WAIT_MAX+1)`.
  - Clears whenever `mem_req` is low or `mem_ready` is high; flags `timeout` at `WAIT_MAX`.
  - Instantiated only under `MCSEQ_TRAP_EN`.

## Test plan
- **Reset release, ADDI, ready tied 1**: `mem_req` first high at edge 2. `ir_we` in FETCH; `rf_we=1`, `pc_we=1`, `pc_sel=0`, `instret` in WB; 4 cycles total.
- **LW, ready low for 3 cycles in MEM**: `mem_addr_sel=1` held and `mem_wen=00` throughout. `mdr_we` only on the ready cycle; `rf_we` one cycle later; 8 cycles total.
- **SH with `mem_we_dec=10`**: `mem_wen=10` only in MEM; `rf_we=0` in WB; `pc_we=1`.
- **BEQ taken (`pcsel_dec=1`)**: WB asserts `pc_we=1`, `pc_sel=1`, `rf_we=0`. Not taken -> `pc_sel=0`.
- **Reset asserted during the 2nd wait cycle of SW**: `mem_req` and `mem_wen` go to 0 in the same cycle. `pc_we`/`rf_we` are never asserted. Restart from IDLE.
- **Opcode 7'b1111111**:
  - With macro: `trap=1` from DECODE+1 and held until reset.
  - Without macro: NOP retire, `pc_we=1`, `pc_sel=0`, `rf_we=0`.
  - With macro and `mem_ready` stuck low in FETCH: trap after 15 wait cycles.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, MemWEn encoding and sequencer state.
package rv32i_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    MEMWEN_NONE = 2'b00,
    MEMWEN_SB   = 2'b01,
    MEMWEN_SH   = 2'b10,
    MEMWEN_SW   = 2'b11
  } mem_wen_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } seq_state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder inputs, memory handshake and datapath enables of the multicycle sequencer.
interface multicycle_sequencer_if;
  logic [6:0] opcode;
  logic [1:0] mem_we_dec;
  logic       reg_wen_dec;
  logic       pcsel_dec;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_addr_sel;
  logic [1:0] mem_wen;
  logic       ir_we;
  logic       mdr_we;
  logic       rf_we;
  logic       pc_we;
  logic       pc_sel;
  logic       instret;
  logic       trap;

  modport master (
    input  opcode, mem_we_dec, reg_wen_dec, pcsel_dec, mem_ready,
    output mem_req, mem_addr_sel, mem_wen, ir_we, mdr_we,
           rf_we, pc_we, pc_sel, instret, trap
  );

  modport slave (
    output opcode, mem_we_dec, reg_wen_dec, pcsel_dec, mem_ready,
    input  mem_req, mem_addr_sel, mem_wen, ir_we, mdr_we,
           rf_we, pc_we, pc_sel, instret, trap
  );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Saturating count of consecutive unanswered memory-request cycles.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic timeout
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (!mem_req || mem_ready)
      count_reg <= '0;
    else if (count_reg != CNT_MAX)
      count_reg <= count_reg + CW'(1);
  end

  // Fires during the WAIT_MAX-th unanswered cycle so the trap lands on the following edge.
  assign timeout = mem_req && !mem_ready && (count_reg >= CNT_LAST);
endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer gating decoder enables and sharing the memory port.
// Optional trap support (illegal opcode, memory wait timeout) under MCSEQ_TRAP_EN.
module multicycle_sequencer
  import rv32i_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);
  seq_state_e state_reg, state_next;
  logic       legal_op;
  logic       mem_req, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_sel, instret, trap;
  logic [1:0] mem_wen;

`ifdef MCSEQ_TRAP_EN
  logic wait_timeout;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_ready (bus.mem_ready),
    .timeout   (wait_timeout)
  );
`endif

  assign legal_op = is_legal_opcode(bus.opcode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_wen      = MEMWEN_NONE;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    instret      = 1'b0;
    trap         = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
`ifdef MCSEQ_TRAP_EN
        else if (wait_timeout)
          state_next = ST_TRAP;
`endif
      end
      ST_DECODE: begin
`ifdef MCSEQ_TRAP_EN
        state_next = legal_op ? ST_EXEC : ST_TRAP;
`else
        state_next = legal_op ? ST_EXEC : ST_WB;
`endif
      end
      ST_EXEC: state_next = is_mem_opcode(bus.opcode) ? ST_MEM : ST_WB;
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (bus.opcode == OP_STORE)
          mem_wen = bus.mem_we_dec;
        if (bus.mem_ready) begin
          mdr_we     = (bus.opcode == OP_LOAD);
          state_next = ST_WB;
        end
`ifdef MCSEQ_TRAP_EN
        else if (wait_timeout)
          state_next = ST_TRAP;
`endif
      end
      ST_WB: begin
        // An illegal opcode retires as a NOP: sequential PC, no register write.
        rf_we      = bus.reg_wen_dec && legal_op;
        pc_we      = 1'b1;
        pc_sel     = bus.pcsel_dec && legal_op;
        instret    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef MCSEQ_TRAP_EN
        trap = 1'b1;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.mem_wen      = mem_wen;
  assign bus.ir_we        = ir_we;
  assign bus.mdr_we       = mdr_we;
  assign bus.rf_we        = rf_we;
  assign bus.pc_we        = pc_we;
  assign bus.pc_sel       = pc_sel;
  assign bus.instret      = instret;
  assign bus.trap         = trap;
endmodule
